// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: pipelined imem requests, in-order response buffer, redirect/halt.
// Optional FETCH_PERF_EN adds saturating bubble and drop counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_addr,
    input  logic        i_halt,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    output logic        o_idle
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] o_perf_bubbles,
    output logic [31:0] o_perf_drops
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DepthC = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {StRun, StHalted} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [31:0]     tag_mem  [FIFO_DEPTH];
    logic [31:0]     inst_mem [FIFO_DEPTH];
    logic [31:0]     pc_mem   [FIFO_DEPTH];

    logic grant, accept, pop, credit, dropping;

    always_comb begin
        credit     = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DepthC;
        o_imem_req = ~i_rst & (state_q == StRun) & ~i_halt & ~i_redirect & credit;
        grant      = o_imem_req & i_imem_gnt;
        dropping   = (drop_cnt_q != '0);
        // Only live responses consume a tag; stale ones predate the flushed tag queue.
        accept     = i_imem_rvalid & ~dropping & ~i_redirect;
        pop        = o_inst_valid & i_inst_ready;
    end

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(i_imem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        fifo_cnt_d    = fifo_cnt_q + CW'(accept) - CW'(pop);
        tag_wr_d      = tag_wr_q + PW'(grant);
        tag_rd_d      = tag_rd_q + PW'(i_imem_rvalid & ~dropping);
        fifo_wr_d     = fifo_wr_q + PW'(accept);
        fifo_rd_d     = fifo_rd_q + PW'(pop);

        unique case (state_q)
            StRun:    if (i_halt && !grant) state_d = StHalted;
            StHalted: if (!i_halt) state_d = StRun;
            default:  state_d = StRun;
        endcase

        if (grant) fetch_addr_d = fetch_addr_q + 32'd4;
        if (i_imem_rvalid && dropping) drop_cnt_d = drop_cnt_q - 1'b1;

        if (i_redirect) begin
            fetch_addr_d = i_redirect_addr & ~32'h3;
            drop_cnt_d   = outstanding_q - CW'(i_imem_rvalid);
            fifo_cnt_d   = '0;
            tag_wr_d     = '0;
            tag_rd_d     = '0;
            fifo_wr_d    = '0;
            fifo_rd_d    = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StRun;
            fetch_addr_q  <= RESET_ADDR & ~32'h3;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (grant) tag_mem[tag_wr_q] <= fetch_addr_q;
        if (accept) begin
            inst_mem[fifo_wr_q] <= i_imem_rdata;
            pc_mem[fifo_wr_q]   <= tag_mem[tag_rd_q];
        end
    end

    assign o_imem_addr  = fetch_addr_q;
    assign o_inst_valid = (fifo_cnt_q != '0);
    assign o_inst       = inst_mem[fifo_rd_q];
    assign o_inst_pc    = pc_mem[fifo_rd_q];
    assign o_idle       = (state_q == StHalted) & (outstanding_q == '0);

`ifdef FETCH_PERF_EN
    logic [32:0]   bubbles_sum, drops_sum;
    logic [CW-1:0] flushed;
    logic          discarded;

    always_comb begin
        flushed     = i_redirect ? (fifo_cnt_q - CW'(pop)) : '0;
        discarded   = i_imem_rvalid & (dropping | i_redirect);
        bubbles_sum = {1'b0, o_perf_bubbles}
                    + 33'((state_q == StRun) & ~i_halt & ~o_inst_valid);
        drops_sum   = {1'b0, o_perf_drops} + 33'(flushed) + 33'(discarded);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_perf_bubbles <= '0;
            o_perf_drops   <= '0;
        end else begin
            o_perf_bubbles <= bubbles_sum[32] ? 32'hFFFF_FFFF : bubbles_sum[31:0];
            o_perf_drops   <= drops_sum[32] ? 32'hFFFF_FFFF : drops_sum[31:0];
        end
    end
`endif

endmodule
